trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_TIMEOUT, default 16: max cycles waited in DRAIN for pipeline idle before forcing entry.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_irq_ext, i_irq_sw, i_irq_tmr  input  1 each  level-sensitive interrupt requests.
REQ-005 SHALL have ports i_exc_valid  input  1, i_exc_cause  input  32, i_exc_pc  input  32, i_exc_tval  input  32  synchronous exception request.
REQ-006 SHALL have ports i_mret  input  1, i_cur_pc  input  32, i_pipe_idle  input  1  return request, PC of next unretired instruction, pipeline drained.
REQ-007 SHALL have ports i_mstatus_mie  input  1, i_mie  input  32  global and per-source enables from CSR.
REQ-008 SHALL have ports o_interrupt_enter, o_interrupt_exit  output  1; o_int_cause, o_int_pc, o_int_mtval  output  32  CSR trap handshake.
REQ-009 SHALL have ports o_stall  output  1, o_flush  output  1, o_mip  output  32  fetch hold, pipeline flush, pending-interrupt view.

Function
REQ-010 SHALL implement states IDLE, DRAIN, ENTER, EXIT.
REQ-011 SHALL treat interrupt k as eligible when i_mstatus_mie=1, i_mie[k]=1 and the source is high; k = 11 ext, 3 sw, 7 tmr.
REQ-012 SHALL prioritize exception > ext > sw > tmr; exceptions are never masked.
REQ-013 SHALL, in IDLE, on any request move to DRAIN and latch cause/pc/tval: exception -> i_exc_cause/i_exc_pc/i_exc_tval; interrupt -> 0x8000000B/0x80000003/0x80000007, i_cur_pc, tval 0.
REQ-014 SHALL, in IDLE with i_mret and no request, go to EXIT; exception or interrupt in the same cycle wins and i_mret is dropped.
REQ-015 SHALL, in DRAIN, replace a latched interrupt with an arriving exception; interrupts never replace a latched entry.
REQ-016 SHALL leave DRAIN for ENTER when i_pipe_idle=1 or when the drain counter reaches DRAIN_TIMEOUT-1.
REQ-017 SHALL assert o_interrupt_enter for exactly one cycle in ENTER, with o_int_* holding the latched values, then return to IDLE.
REQ-018 SHALL assert o_interrupt_exit for exactly one cycle in EXIT, then return to IDLE.
REQ-019 SHALL accept no new request in ENTER or EXIT; an interrupt still eligible is taken from IDLE on the following cycle.
REQ-020 SHALL assert o_stall in DRAIN and ENTER, o_flush in ENTER and EXIT.
REQ-021 SHALL drive o_mip bits 11/3/7 from raw source levels regardless of enables; other bits 0.
REQ-022 SHALL clear the drain counter on DRAIN entry and saturate it at DRAIN_TIMEOUT-1.
REQ-023 SHALL deliver minimum latency from request in IDLE to o_interrupt_enter of 2 cycles (request edge N -> DRAIN, idle seen -> ENTER at N+2).

Reset
REQ-024 SHALL on rst low immediately force IDLE, counter 0, latched cause/pc/tval 0, all outputs 0, including mid-DRAIN or mid-ENTER.
REQ-025 SHALL resume sampling requests on the first rising clk after rst deasserts.

Configuration
REQ-026 SHALL, with TRAP_CTRL_IRQ_SYNC_EN defined, pass the three irq inputs through 2-flop synchronizers (reset 0) before eligibility and o_mip, adding 2 cycles of irq latency.
REQ-027 SHALL, without TRAP_CTRL_IRQ_SYNC_EN, use the irq inputs directly; exception and mret paths are unaffected either way.

Verification
REQ-028 SHALL cover: i_exc_valid=1, cause 0x2, pc 0x100, tval 0xDEAD, i_pipe_idle=1 -> one-cycle enter 2 cycles later with cause 0x2, pc 0x100, mtval 0xDEAD.
REQ-029 SHALL cover: ext+tmr high, mie[11]=mie[7]=1, mstatus_mie=1, i_cur_pc 0x200 -> cause 0x8000000B, pc 0x200, mtval 0.
REQ-030 SHALL cover: i_pipe_idle held 0 -> enter asserted exactly DRAIN_TIMEOUT cycles after DRAIN entry, o_stall high throughout.
REQ-031 SHALL cover: tmr latched in DRAIN, then exception cause 0x5 -> enter reports 0x5; same-cycle i_mret and i_exc_valid -> no exit pulse.
REQ-032 SHALL cover: i_mret alone in IDLE -> o_interrupt_exit and o_flush high for exactly one cycle; rst low during DRAIN -> all outputs 0 and no enter pulse.

Source files
------------

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap entry/exit sequencer; optional irq synchronizers via TRAP_CTRL_IRQ_SYNC_EN
module trap_ctrl #(
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_irq_ext,
  input  logic        i_irq_sw,
  input  logic        i_irq_tmr,
  input  logic        i_exc_valid,
  input  logic [31:0] i_exc_cause,
  input  logic [31:0] i_exc_pc,
  input  logic [31:0] i_exc_tval,
  input  logic        i_mret,
  input  logic [31:0] i_cur_pc,
  input  logic        i_pipe_idle,
  input  logic        i_mstatus_mie,
  input  logic [31:0] i_mie,
  output logic        o_interrupt_enter,
  output logic        o_interrupt_exit,
  output logic [31:0] o_int_cause,
  output logic [31:0] o_int_pc,
  output logic [31:0] o_int_mtval,
  output logic        o_stall,
  output logic        o_flush,
  output logic [31:0] o_mip
);

  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ENTER, S_EXIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   lat_cause, lat_pc, lat_tval;
  logic          lat_is_irq;
  logic          take_req, take_exc;
  logic [2:0]    irq_lvl;
  logic          ext_el, sw_el, tmr_el, req_any;
  logic [31:0]   irq_cause;

  // only the three implemented source enables are consulted
  logic unused_mie;
  assign unused_mie = ^{i_mie[31:12], i_mie[10:8], i_mie[6:4], i_mie[2:0]};

`ifdef TRAP_CTRL_IRQ_SYNC_EN
  logic [2:0] irq_s1, irq_s2;
  // two-flop synchronizer on the asynchronous interrupt levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_s1 <= 3'b000;
      irq_s2 <= 3'b000;
    end else begin
      irq_s1 <= {i_irq_ext, i_irq_sw, i_irq_tmr};
      irq_s2 <= irq_s1;
    end
  end
  assign irq_lvl = irq_s2;
`else
  assign irq_lvl = {i_irq_ext, i_irq_sw, i_irq_tmr};
`endif

  assign ext_el  = i_mstatus_mie & i_mie[11] & irq_lvl[2];
  assign sw_el   = i_mstatus_mie & i_mie[3]  & irq_lvl[1];
  assign tmr_el  = i_mstatus_mie & i_mie[7]  & irq_lvl[0];
  assign req_any = i_exc_valid | ext_el | sw_el | tmr_el;

  assign irq_cause = ext_el ? 32'h8000_000B :
                     sw_el  ? 32'h8000_0003 : 32'h8000_0007;

  // pending view follows raw levels, forced low while reset is held
  assign o_mip = rst ? {20'd0, irq_lvl[2], 3'd0, irq_lvl[0], 3'd0, irq_lvl[1], 3'd0} : 32'd0;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt         = state;
    take_req          = 1'b0;
    take_exc          = 1'b0;
    o_interrupt_enter = 1'b0;
    o_interrupt_exit  = 1'b0;
    o_stall           = 1'b0;
    o_flush           = 1'b0;
    o_int_cause       = 32'd0;
    o_int_pc          = 32'd0;
    o_int_mtval       = 32'd0;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          state_nxt = S_DRAIN;
          take_req  = 1'b1;
        end else if (i_mret) begin
          state_nxt = S_EXIT;
        end
      end
      S_DRAIN: begin
        o_stall  = 1'b1;
        take_exc = i_exc_valid & lat_is_irq;
        if (i_pipe_idle || cnt == CNT_MAX) state_nxt = S_ENTER;
      end
      S_ENTER: begin
        o_interrupt_enter = 1'b1;
        o_stall           = 1'b1;
        o_flush           = 1'b1;
        o_int_cause       = lat_cause;
        o_int_pc          = lat_pc;
        o_int_mtval       = lat_tval;
        state_nxt         = S_IDLE;
      end
      S_EXIT: begin
        o_interrupt_exit = 1'b1;
        o_flush          = 1'b1;
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // trap record latch and saturating drain counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      lat_cause  <= 32'd0;
      lat_pc     <= 32'd0;
      lat_tval   <= 32'd0;
      lat_is_irq <= 1'b0;
    end else if (take_req) begin
      cnt <= '0;
      if (i_exc_valid) begin
        lat_cause  <= i_exc_cause;
        lat_pc     <= i_exc_pc;
        lat_tval   <= i_exc_tval;
        lat_is_irq <= 1'b0;
      end else begin
        lat_cause  <= irq_cause;
        lat_pc     <= i_cur_pc;
        lat_tval   <= 32'd0;
        lat_is_irq <= 1'b1;
      end
    end else if (state == S_DRAIN) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (take_exc) begin
        lat_cause  <= i_exc_cause;
        lat_pc     <= i_exc_pc;
        lat_tval   <= i_exc_tval;
        lat_is_irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_irq_ext, i_irq_sw, i_irq_tmr;
  logic        i_exc_valid;
  logic [31:0] i_exc_cause, i_exc_pc, i_exc_tval;
  logic        i_mret;
  logic [31:0] i_cur_pc;
  logic        i_pipe_idle;
  logic        i_mstatus_mie;
  logic [31:0] i_mie;
  logic        o_interrupt_enter, o_interrupt_exit;
  logic [31:0] o_int_cause, o_int_pc, o_int_mtval;
  logic        o_stall, o_flush;
  logic [31:0] o_mip;
  logic [3:0]  ctl;

  int vectors = 0;
  int miscompares = 0;

  // ctl encodes {enter, exit, stall, flush}: idle 0000, drain 0010, enter 1011, exit 0101
  assign ctl = {o_interrupt_enter, o_interrupt_exit, o_stall, o_flush};

  trap_ctrl #(.DRAIN_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_irq_ext(i_irq_ext), .i_irq_sw(i_irq_sw), .i_irq_tmr(i_irq_tmr),
    .i_exc_valid(i_exc_valid), .i_exc_cause(i_exc_cause), .i_exc_pc(i_exc_pc),
    .i_exc_tval(i_exc_tval), .i_mret(i_mret), .i_cur_pc(i_cur_pc),
    .i_pipe_idle(i_pipe_idle), .i_mstatus_mie(i_mstatus_mie), .i_mie(i_mie),
    .o_interrupt_enter(o_interrupt_enter), .o_interrupt_exit(o_interrupt_exit),
    .o_int_cause(o_int_cause), .o_int_pc(o_int_pc), .o_int_mtval(o_int_mtval),
    .o_stall(o_stall), .o_flush(o_flush), .o_mip(o_mip)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic quiet_inputs();
    i_irq_ext = 0; i_irq_sw = 0; i_irq_tmr = 0;
    i_exc_valid = 0; i_exc_cause = 0; i_exc_pc = 0; i_exc_tval = 0;
    i_mret = 0; i_cur_pc = 0; i_pipe_idle = 1;
    i_mstatus_mie = 0; i_mie = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    quiet_inputs();
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000 || o_int_cause !== 0 || o_int_pc !== 0 || o_int_mtval !== 0) begin
      miscompares++;
      $display("FAIL reset_outputs ctl=%b cause=%h pc=%h tval=%h want all 0", ctl, o_int_cause, o_int_pc, o_int_mtval);
    end
    i_irq_ext = 1; #1;
    vectors++;
    if (o_mip !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mip got=%h want=0", o_mip);
    end
    i_irq_ext = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_reset_idle ctl=%b want=0000", ctl);
    end
  endtask

  task automatic test_exception();
    @(negedge clk);
    i_exc_valid = 1; i_exc_cause = 32'h2; i_exc_pc = 32'h100; i_exc_tval = 32'hDEAD; i_pipe_idle = 1;
    @(negedge clk);
    i_exc_valid = 0;
    vectors++;
    if (ctl !== 4'b0010) begin
      miscompares++;
      $display("FAIL exc_drain ctl=%b want=0010", ctl);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1011 || o_int_cause !== 32'h2 || o_int_pc !== 32'h100 || o_int_mtval !== 32'hDEAD) begin
      miscompares++;
      $display("FAIL exc_enter ctl=%b cause=%h pc=%h tval=%h want 1011/2/100/dead", ctl, o_int_cause, o_int_pc, o_int_mtval);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++;
      $display("FAIL exc_one_pulse ctl=%b want=0000", ctl);
    end
  endtask

  task automatic test_irq_priority();
    @(negedge clk);
    i_irq_ext = 1; i_irq_tmr = 1; i_mie = 32'h880; i_mstatus_mie = 1; i_cur_pc = 32'h200; i_pipe_idle = 1;
    #1;
    vectors++;
    if (o_mip !== 32'h880) begin
      miscompares++;
      $display("FAIL mip_ext_tmr got=%h want=00000880", o_mip);
    end
    @(negedge clk);
    i_irq_ext = 0; i_irq_tmr = 0;
    vectors++;
    if (ctl !== 4'b0010) begin
      miscompares++;
      $display("FAIL irq_drain ctl=%b want=0010", ctl);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1011 || o_int_cause !== 32'h8000000B || o_int_pc !== 32'h200 || o_int_mtval !== 32'h0) begin
      miscompares++;
      $display("FAIL irq_enter ctl=%b cause=%h pc=%h tval=%h want 1011/8000000b/200/0", ctl, o_int_cause, o_int_pc, o_int_mtval);
    end
    @(negedge clk);
    quiet_inputs();
  endtask

  task automatic test_mask();
    @(negedge clk);
    i_mstatus_mie = 0; i_mie = 32'h888; i_irq_sw = 1; i_irq_tmr = 1;
    #1;
    vectors++;
    if (o_mip !== 32'h88) begin
      miscompares++;
      $display("FAIL mip_masked got=%h want=00000088", o_mip);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++;
      $display("FAIL global_mask ctl=%b want=0000", ctl);
    end
    i_irq_sw = 0; i_irq_tmr = 0; i_mstatus_mie = 1; i_mie = 32'h0; i_irq_ext = 1;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++;
      $display("FAIL source_mask ctl=%b want=0000", ctl);
    end
    quiet_inputs();
  endtask

  task automatic test_timeout();
    @(negedge clk);
    i_pipe_idle = 0; i_exc_valid = 1; i_exc_cause = 32'h3; i_exc_pc = 32'h40; i_exc_tval = 32'h0;
    @(negedge clk);
    i_exc_valid = 0;
    for (int i = 1; i <= 16; i++) begin
      vectors++;
      if (ctl !== 4'b0010) begin
        miscompares++;
        $display("FAIL timeout_drain cycle=%0d ctl=%b want=0010", i, ctl);
      end
      if (i < 16) @(negedge clk);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1011 || o_int_cause !== 32'h3) begin
      miscompares++;
      $display("FAIL timeout_enter ctl=%b cause=%h want 1011/3", ctl, o_int_cause);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++;
      $display("FAIL timeout_after ctl=%b want=0000", ctl);
    end
    quiet_inputs();
  endtask

  task automatic test_replace();
    @(negedge clk);
    i_pipe_idle = 0; i_mstatus_mie = 1; i_mie = 32'h880; i_irq_tmr = 1; i_cur_pc = 32'h300;
    @(negedge clk);
    i_irq_tmr = 0;
    i_exc_valid = 1; i_exc_cause = 32'h5; i_exc_pc = 32'h400; i_exc_tval = 32'h11;
    @(negedge clk);
    i_exc_valid = 0; i_irq_ext = 1; i_pipe_idle = 1;
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1011 || o_int_cause !== 32'h5 || o_int_pc !== 32'h400 || o_int_mtval !== 32'h11) begin
      miscompares++;
      $display("FAIL replace_enter ctl=%b cause=%h pc=%h tval=%h want 1011/5/400/11", ctl, o_int_cause, o_int_pc, o_int_mtval);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++;
      $display("FAIL enter_blocks_req ctl=%b want=0000", ctl);
    end
    @(negedge clk);
    i_irq_ext = 0;
    vectors++;
    if (ctl !== 4'b0010) begin
      miscompares++;
      $display("FAIL retake_pending ctl=%b want=0010", ctl);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1011 || o_int_cause !== 32'h8000000B) begin
      miscompares++;
      $display("FAIL retake_enter ctl=%b cause=%h want 1011/8000000b", ctl, o_int_cause);
    end
    @(negedge clk);
    quiet_inputs();
  endtask

  task automatic test_mret();
    @(negedge clk);
    i_mret = 1; i_exc_valid = 1; i_exc_cause = 32'h4; i_pipe_idle = 1;
    @(negedge clk);
    i_mret = 0; i_exc_valid = 0;
    vectors++;
    if (ctl !== 4'b0010) begin
      miscompares++;
      $display("FAIL mret_exc_drain ctl=%b want=0010", ctl);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1011 || o_int_cause !== 32'h4) begin
      miscompares++;
      $display("FAIL mret_exc_enter ctl=%b cause=%h want 1011/4", ctl, o_int_cause);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++;
      $display("FAIL mret_dropped ctl=%b want=0000", ctl);
    end
    i_mret = 1;
    @(negedge clk);
    i_mret = 0;
    vectors++;
    if (ctl !== 4'b0101) begin
      miscompares++;
      $display("FAIL mret_exit ctl=%b want=0101", ctl);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b0000) begin
      miscompares++;
      $display("FAIL mret_one_pulse ctl=%b want=0000", ctl);
    end
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    i_pipe_idle = 0; i_exc_valid = 1; i_exc_cause = 32'h9; i_exc_pc = 32'h80;
    @(negedge clk);
    i_exc_valid = 0;
    vectors++;
    if (ctl !== 4'b0010) begin
      miscompares++;
      $display("FAIL mid_drain_pre ctl=%b want=0010", ctl);
    end
    i_irq_ext = 1; i_pipe_idle = 1;
    rst = 0;
    #1;
    vectors++;
    if (ctl !== 4'b0000 || o_int_cause !== 0 || o_mip !== 0) begin
      miscompares++;
      $display("FAIL mid_drain_reset ctl=%b cause=%h mip=%h want all 0", ctl, o_int_cause, o_mip);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (ctl !== 4'b0000) begin
        miscompares++;
        $display("FAIL held_reset cycle=%0d ctl=%b want=0000", i, ctl);
      end
    end
    i_irq_ext = 0;
    rst = 1;
    i_exc_valid = 1; i_exc_cause = 32'h7; i_exc_pc = 32'h90; i_exc_tval = 32'h1;
    @(negedge clk);
    i_exc_valid = 0;
    vectors++;
    if (ctl !== 4'b0010) begin
      miscompares++;
      $display("FAIL resume_drain ctl=%b want=0010", ctl);
    end
    @(negedge clk);
    vectors++;
    if (ctl !== 4'b1011 || o_int_cause !== 32'h7 || o_int_pc !== 32'h90) begin
      miscompares++;
      $display("FAIL resume_enter ctl=%b cause=%h pc=%h want 1011/7/90", ctl, o_int_cause, o_int_pc);
    end
    @(negedge clk);
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_exception();
    test_irq_priority();
    test_mask();
    test_timeout();
    test_replace();
    test_mret();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
